// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: the response code enum and byte-lane width.
package axi4_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  // Width of one byte lane inside a data word.
  localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) with manager and subordinate views.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where both valid and ready are 1. The source raises valid independently of
// ready and holds valid and payload stable until that edge; ready may wait
// for valid.
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;

  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;

  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;

  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;

  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport manager (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport subordinate (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );

endinterface

// File: rtl/axi4_lite_sub_regbank.sv
// AXI4-Lite CSR bank: NUM_REGS software-visible registers with one outstanding
// write and one outstanding read, handled by independent paths. All handshake
// outputs come straight from flops.
module axi4_lite_sub_regbank
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  axi4_if.subordinate                    s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int LSB   = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * BYTES);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // Write holding buffers (AW and W arrive independently).
  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [BYTES-1:0]      w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  aw_have;
  logic                  w_have;
  logic                  aw_full_next;
  logic                  w_full_next;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]      wr_strb;
  logic                  wr_hit;

  logic                  ar_hs;
  logic                  r_hs;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_word;

  // Protection bits carry no meaning for this bank.
  logic unused_prot;
  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid  && s_axi.wready;
  assign b_hs  = s_axi.bvalid  && s_axi.bready;

  // A buffer counts as full on the edge it is being filled, so a combined
  // AW+W handshake commits immediately (bvalid on the next cycle).
  assign aw_have = aw_full || aw_hs;
  assign w_have  = w_full  || w_hs;
  assign commit  = aw_have && w_have && !s_axi.bvalid;

  assign wr_addr = aw_full ? aw_addr_q : s_axi.awaddr;
  assign wr_data = w_full  ? w_data_q  : s_axi.wdata;
  assign wr_strb = w_full  ? w_strb_q  : s_axi.wstrb;
  assign wr_idx  = wr_addr >> LSB;
  assign wr_hit  = wr_addr < SPAN;

  // Buffers stay occupied through the B phase and drain on the B handshake.
  assign aw_full_next = b_hs ? 1'b0 : aw_have;
  assign w_full_next  = b_hs ? 1'b0 : w_have;

  // Write control: buffer capture, ready generation and B response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= OKAY;
    end else begin
      aw_full       <= aw_full_next;
      w_full        <= w_full_next;
      s_axi.awready <= !aw_full_next;
      s_axi.wready  <= !w_full_next;
      if (aw_hs) aw_addr_q <= s_axi.awaddr;
      if (w_hs) begin
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      if (commit) begin
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= wr_hit ? OKAY : SLVERR;
      end else if (b_hs) begin
        s_axi.bvalid <= 1'b0;
      end
    end
  end

  // Register storage: byte-masked update of the addressed register at commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (commit && wr_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == ADDR_WIDTH'(i)) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wr_strb[b]) regs[i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  assign regs_o = regs;

  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign r_hs   = s_axi.rvalid  && s_axi.rready;
  assign rd_idx = s_axi.araddr >> LSB;
  assign rd_hit = s_axi.araddr < SPAN;

  // Read mux over the current (pre-commit) register contents.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == ADDR_WIDTH'(i)) rd_word = regs[i];
    end
  end

  // Read control: capture data at AR handshake, hold until R handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= OKAY;
    end else begin
      if (ar_hs) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata  <= rd_hit ? rd_word : '0;
        s_axi.rresp  <= rd_hit ? OKAY : SLVERR;
      end else if (r_hs) begin
        s_axi.rvalid <= 1'b0;
      end
      s_axi.arready <= !(ar_hs || (s_axi.rvalid && !r_hs));
    end
  end

endmodule
